// File: rtl/oam_dma_arbiter_if.sv
// rtl/oam_dma_arbiter_if.sv - cpu, system bus and OAM signal bundle for oam_dma_arbiter
// Names are from the arbiter's point of view: i_ = into the arbiter, o_ = out of it.
interface oam_dma_arbiter_if;
    logic [1:0]  i_t_cycle;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_enable;
    logic        i_cpu_write;
    logic [7:0]  i_cpu_wdata;
    logic [7:0]  o_cpu_rdata;
    logic [15:0] o_bus_addr;
    logic        o_bus_enable;
    logic        o_bus_write;
    logic [7:0]  o_bus_wdata;
    logic [7:0]  i_bus_rdata;
    logic [7:0]  o_oam_addr;
    logic        o_oam_we;
    logic [7:0]  o_oam_wdata;
    logic        o_dma_active;

    modport slave (
        input  i_t_cycle, i_cpu_addr, i_cpu_enable, i_cpu_write, i_cpu_wdata, i_bus_rdata,
        output o_cpu_rdata, o_bus_addr, o_bus_enable, o_bus_write, o_bus_wdata,
        output o_oam_addr, o_oam_we, o_oam_wdata, o_dma_active
    );

    modport master (
        output i_t_cycle, i_cpu_addr, i_cpu_enable, i_cpu_write, i_cpu_wdata, i_bus_rdata,
        input  o_cpu_rdata, o_bus_addr, o_bus_enable, o_bus_write, o_bus_wdata,
        input  o_oam_addr, o_oam_we, o_oam_wdata, o_dma_active
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - cpu/system bus arbiter with GameBoy OAM DMA engine
// Optional DMA_BUS_CONFLICT_EN: blocked cpu reads see the byte the DMA is reading instead of 8'hFF.
module oam_dma_arbiter #(
    parameter int          OAM_LEN         = 160,
    parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46,
    parameter int          STARTUP_MCYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    oam_dma_arbiter_if.slave bus
);
    localparam int          CW       = $clog2(STARTUP_MCYCLES + 1);
    localparam logic [7:0]  LAST_IDX = 8'(OAM_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_src;
    logic [7:0]      r_idx;
    logic [CW-1:0]   r_count;
    logic            r_hold;
    logic            r_oam_we;
    logic [7:0]      r_oam_addr;
    logic [7:0]      r_oam_wdata;

    state_t          w_state_nxt;
    logic [7:0]      w_src_nxt;
    logic [7:0]      w_idx_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic            w_hold_nxt;
    logic            w_oam_we_nxt;
    logic [7:0]      w_oam_addr_nxt;
    logic [7:0]      w_oam_wdata_nxt;

    logic            w_mboundary;
    logic            w_cpu_ff;
    logic            w_trigger;
    logic            w_dma_active;
    logic            w_dma_drive;
    logic [7:0]      w_eff_src;
    logic [15:0]     w_bus_addr;
    logic            w_bus_enable;
    logic            w_bus_write;
    logic [7:0]      w_cpu_rdata;

    assign w_mboundary  = (bus.i_t_cycle == 2'd3);
    assign w_cpu_ff     = bus.i_cpu_enable && (bus.i_cpu_addr[15:8] == 8'hFF);
    assign w_trigger    = bus.i_cpu_enable && bus.i_cpu_write
                       && (bus.i_cpu_addr == DMA_REG_ADDR) && w_mboundary;
    assign w_dma_active = (r_state == ST_XFER) || ((r_state == ST_START) && r_hold);
    // An FF-page cpu access steals the bus for its M-cycle; the DMA retries the same index.
    assign w_dma_drive  = (r_state == ST_XFER) && !w_cpu_ff;
    assign w_eff_src    = (r_src >= 8'hE0) ? (r_src - 8'h20) : r_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_src       <= 8'h00;
            r_idx       <= 8'h00;
            r_count     <= '0;
            r_hold      <= 1'b0;
            r_oam_we    <= 1'b0;
            r_oam_addr  <= 8'h00;
            r_oam_wdata <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_idx       <= w_idx_nxt;
            r_count     <= w_count_nxt;
            r_hold      <= w_hold_nxt;
            r_oam_we    <= w_oam_we_nxt;
            r_oam_addr  <= w_oam_addr_nxt;
            r_oam_wdata <= w_oam_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_src_nxt       = r_src;
        w_idx_nxt       = r_idx;
        w_count_nxt     = r_count;
        w_hold_nxt      = r_hold;
        w_oam_we_nxt    = 1'b0;
        w_oam_addr_nxt  = r_oam_addr;
        w_oam_wdata_nxt = r_oam_wdata;

        if (w_trigger) begin
            // A restart from an owning state keeps the bus so the cpu never sees a gap.
            w_src_nxt   = bus.i_cpu_wdata;
            w_idx_nxt   = 8'h00;
            w_count_nxt = CW'(STARTUP_MCYCLES);
            w_state_nxt = ST_START;
            w_hold_nxt  = w_dma_active;
        end else begin
            unique case (r_state)
                ST_START: begin
                    if (w_mboundary) begin
                        w_count_nxt = r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            w_state_nxt = ST_XFER;
                            w_hold_nxt  = 1'b0;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_mboundary && w_dma_drive) begin
                        w_oam_we_nxt    = 1'b1;
                        w_oam_addr_nxt  = r_idx;
                        w_oam_wdata_nxt = bus.i_bus_rdata;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = 8'h00;
                        end else begin
                            w_idx_nxt   = r_idx + 8'h01;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_bus_addr   = bus.i_cpu_addr;
        w_bus_enable = bus.i_cpu_enable;
        w_bus_write  = bus.i_cpu_write;
        if (w_dma_drive) begin
            w_bus_addr   = {w_eff_src, r_idx};
            w_bus_enable = 1'b1;
            w_bus_write  = 1'b0;
        end else if (w_dma_active && !w_cpu_ff) begin
            w_bus_enable = 1'b0;
            w_bus_write  = 1'b0;
        end
    end

    always_comb begin
        w_cpu_rdata = bus.i_bus_rdata;
        if (bus.i_cpu_addr == DMA_REG_ADDR) begin
            w_cpu_rdata = r_src;
        end else if (w_dma_active && (bus.i_cpu_addr[15:8] != 8'hFF)) begin
`ifdef DMA_BUS_CONFLICT_EN
            w_cpu_rdata = bus.i_bus_rdata;
`else
            w_cpu_rdata = 8'hFF;
`endif
        end
    end

    assign bus.o_bus_addr   = w_bus_addr;
    assign bus.o_bus_enable = w_bus_enable;
    assign bus.o_bus_write  = w_bus_write;
    assign bus.o_bus_wdata  = bus.i_cpu_wdata;
    assign bus.o_cpu_rdata  = w_cpu_rdata;
    assign bus.o_oam_we     = r_oam_we;
    assign bus.o_oam_addr   = r_oam_addr;
    assign bus.o_oam_wdata  = r_oam_wdata;
    assign bus.o_dma_active = w_dma_active;
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - scoreboard bench for oam_dma_arbiter against a memory-image model
module tb_oam_dma_arbiter;
    logic clk;
    logic reset;
    logic [1:0] tb_t = 2'd0;
    logic [7:0] mem [0:65535];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    logic        s_active;
    logic [7:0]  s_rdata;
    logic [15:0] s_baddr;
    logic        s_ben;
    logic        s_bwr;

    oam_dma_arbiter_if ifc ();

    oam_dma_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tb_t <= tb_t + 2'd1;
    assign ifc.i_t_cycle   = tb_t;
    assign ifc.i_bus_rdata = mem[ifc.o_bus_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] eff(input logic [7:0] src);
        return (src >= 8'hE0) ? src - 8'h20 : src;
    endfunction

    function automatic void push_xfer(input logic [7:0] src, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.a = 8'(i);
            e.d = mem[{eff(src), 8'(i)}];
            sbq.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && ifc.o_oam_we === 1'b1) begin
            exp_t e;
            we_count++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL oam_unexpected actual=addr %h required=no write", ifc.o_oam_addr);
            end else begin
                e = sbq.pop_front();
                chk("oam_addr", 32'(ifc.o_oam_addr), 32'(e.a));
                chk("oam_wdata", 32'(ifc.o_oam_wdata), 32'(e.d));
            end
        end
    end

    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (tb_t != 2'd0);
    endtask

    task automatic mc(input logic en, input logic wr, input logic [15:0] a, input logic [7:0] d);
        ifc.i_cpu_enable = en;
        ifc.i_cpu_write  = wr;
        ifc.i_cpu_addr   = a;
        ifc.i_cpu_wdata  = d;
        @(negedge clk);
        s_active = ifc.o_dma_active;
        s_rdata  = ifc.o_cpu_rdata;
        s_baddr  = ifc.o_bus_addr;
        s_ben    = ifc.o_bus_enable;
        s_bwr    = ifc.o_bus_write;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mc(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic trigger(input logic [7:0] src);
        mc(1'b1, 1'b1, 16'hFF46, src);
    endtask

    task automatic run_until_done(output int n);
        n = 0;
        for (int k = 0; k < 600; k++) begin
            idle();
            if (!s_active) break;
            n++;
        end
    endtask

    task automatic random_xfer();
        logic [7:0]  src;
        logic [15:0] a;
        int n_ff, n_act, lidx, r;
        src   = 8'($urandom_range(0, 255));
        n_ff  = 0;
        n_act = 0;
        lidx  = 0;
        trigger(src);
        push_xfer(src, 160);
        idle();
        chk("rnd_startup_inactive", 32'(s_active), 32'd0);
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 7);
            if (r < 2) begin
                a = 16'hFF80 + 16'($urandom_range(0, 126));
                mc(1'b1, 1'b0, a, 8'h00);
                chk("rnd_ff_read", 32'(s_rdata), 32'(mem[a]));
                if (s_active) n_ff++;
            end else if (r == 2) begin
                a = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
                mc(1'b1, 1'b0, a, 8'h00);
                if (s_active) begin
`ifdef DMA_BUS_CONFLICT_EN
                    chk("rnd_blocked_read", 32'(s_rdata), 32'(mem[{eff(src), 8'(lidx)}]));
`else
                    chk("rnd_blocked_read", 32'(s_rdata), 32'hFF);
`endif
                    lidx++;
                end
            end else begin
                idle();
                if (s_active) lidx++;
            end
            if (!s_active) break;
            n_act++;
        end
        chk("rnd_active_mcycles", 32'(n_act), 32'(160 + n_ff));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int we_snap;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        reset            = 1'b1;
        ifc.i_cpu_enable = 1'b0;
        ifc.i_cpu_write  = 1'b0;
        ifc.i_cpu_addr   = 16'h0000;
        ifc.i_cpu_wdata  = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_dma_active", 32'(ifc.o_dma_active), 32'd0);
        chk("rst_oam_we", 32'(ifc.o_oam_we), 32'd0);
        chk("rst_oam_addr", 32'(ifc.o_oam_addr), 32'd0);
        chk("rst_oam_wdata", 32'(ifc.o_oam_wdata), 32'd0);
        reset = 1'b0;
        align();

        mc(1'b1, 1'b0, 16'h1234, 8'h00);
        chk("pass_bus_addr", 32'(s_baddr), 32'h1234);
        chk("pass_bus_enable", 32'(s_ben), 32'd1);
        chk("pass_cpu_rdata", 32'(s_rdata), 32'(mem[16'h1234]));
        chk("pass_dma_active", 32'(s_active), 32'd0);

        trigger(8'hC1);
        push_xfer(8'hC1, 160);
        idle();
        chk("c1_startup_inactive", 32'(s_active), 32'd0);
        run_until_done(n);
        chk("c1_active_mcycles", 32'(n), 32'd160);
        mc(1'b1, 1'b0, 16'hFF46, 8'h00);
        chk("c1_reg_read", 32'(s_rdata), 32'hC1);

        trigger(8'hE3);
        push_xfer(8'hE3, 160);
        idle();
        run_until_done(n);
        chk("e3_active_mcycles", 32'(n), 32'd160);

        trigger(8'hC1);
        push_xfer(8'hC1, 160);
        idle();
        repeat (5) idle();
        mc(1'b1, 1'b0, 16'h8000, 8'h00);
`ifdef DMA_BUS_CONFLICT_EN
        chk("blocked_read_8000", 32'(s_rdata), 32'(mem[16'hC105]));
`else
        chk("blocked_read_8000", 32'(s_rdata), 32'hFF);
`endif
        mc(1'b1, 1'b1, 16'hC000, 8'h55);
        chk("blocked_write_c000", 32'(s_bwr), 32'd0);
        mc(1'b1, 1'b0, 16'hFF80, 8'h00);
        chk("hram_bus_addr", 32'(s_baddr), 32'hFF80);
        chk("hram_read", 32'(s_rdata), 32'(mem[16'hFF80]));
        run_until_done(n);
        chk("stretch_active_mcycles", 32'(n + 8), 32'd161);

        trigger(8'hC5);
        push_xfer(8'hC5, 50);
        idle();
        repeat (50) idle();
        trigger(8'hD0);
        push_xfer(8'hD0, 160);
        chk("restart_active_on_trigger", 32'(s_active), 32'd1);
        idle();
        chk("restart_active_held", 32'(s_active), 32'd1);
        run_until_done(n);
        chk("restart_active_mcycles", 32'(n), 32'd160);

        random_xfer();
        random_xfer();

        trigger(8'hC2);
        push_xfer(8'hC2, 10);
        idle();
        repeat (10) idle();
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_dma_active", 32'(ifc.o_dma_active), 32'd0);
        chk("abort_oam_we", 32'(ifc.o_oam_we), 32'd0);
        we_snap = we_count;
        align();
        mc(1'b1, 1'b0, 16'hFF46, 8'h00);
        chk("abort_src_cleared", 32'(s_rdata), 32'h00);
        repeat (20) idle();
        chk("abort_no_more_we", 32'(we_count - we_snap), 32'd0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
